// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types for the slave-port arbiter: transfer types and FSM states.
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_type;

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible requester at or after
// 'start' (wrapping modulo MASTER_NUM), skipping any bit set in 'exclude'.
module ahb_rr_picker #(
  parameter int MASTER_NUM = 3,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      start,
  input  logic [MASTER_NUM-1:0] exclude,
  output logic [IDX_W-1:0]      winner,
  output logic                  found
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(MASTER_NUM);

  // cand[gi] is the master index visited at search offset gi
  logic [IDX_W-1:0]      cand [MASTER_NUM];
  logic [MASTER_NUM-1:0] eligible;

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_NUM; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, start} + (IDX_W+1)'(gi);
      assign cand[gi]     = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : IDX_W'(sum);
      assign eligible[gi] = req[cand[gi]] & ~exclude[cand[gi]];
    end
  endgenerate

  // Priority encode over search offsets; the lowest offset wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = cand[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter for one AHB slave port shared by several masters.
// Bursts (SEQ/BUSY) lock the grant; long-running owners are pre-empted at
// NONSEQ/IDLE boundaries once they have completed MAX_HOLD beats.
module ahb_slave_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 3,
  parameter int MAX_HOLD   = 16,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hreq,
  input  htrans_type            htrans [MASTER_NUM],
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [IDX_W-1:0]      hmaster,
  output logic [IDX_W-1:0]      hmaster_data,
  output logic                  hmaster_valid
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MASTER_NUM - 1);

  arb_state_type         state_reg, state_next;
  logic [MASTER_NUM-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]      owner_reg, owner_next;
  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [IDX_W-1:0]      hmaster_reg, hmaster_data_reg;
  logic                  hmaster_valid_reg;

  logic [IDX_W-1:0] start_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  htrans_type       owner_trans;
  logic             burst_lock, owner_release, hold_sat;

  assign start_ptr     = (rr_ptr_reg == LAST_IDX) ? '0 : rr_ptr_reg + IDX_W'(1);
  assign owner_trans   = htrans[owner_reg];
  assign burst_lock    = hreq[owner_reg] && (owner_trans == SEQ || owner_trans == BUSY);
  assign owner_release = !hreq[owner_reg] || (owner_trans == IDLE);
  assign hold_sat      = (hold_cnt_reg >= HOLD_MAX);

  // The current owner is always excluded; in ARB_IDLE grant_reg is zero.
  ahb_rr_picker #(
    .MASTER_NUM (MASTER_NUM),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req     (hreq),
    .start   (start_ptr),
    .exclude (grant_reg),
    .winner  (pick_idx),
    .found   (pick_found)
  );

  // Next-state arbitration: grant, burst lock, release and pre-emption
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    if (state_reg == ARB_IDLE) begin
      if (pick_found) begin
        state_next    = ARB_OWN;
        grant_next    = MASTER_NUM'(1) << pick_idx;
        owner_next    = pick_idx;
        rr_ptr_next   = pick_idx;
        hold_cnt_next = '0;
      end
    end else if (burst_lock) begin
      // BUSY beats do not count towards the hold budget
      if (owner_trans == SEQ && !hold_sat) hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end else if (owner_release || (hold_sat && pick_found)) begin
      hold_cnt_next = '0;
      if (pick_found) begin
        grant_next  = MASTER_NUM'(1) << pick_idx;
        owner_next  = pick_idx;
        rr_ptr_next = pick_idx;
      end else begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    end else if (!hold_sat) begin
      // Owner continues with NONSEQ and nobody is waiting, or budget not spent
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end
  end

  // State, grant and ownership pipeline advance only on hready edges
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg         <= ARB_IDLE;
      grant_reg         <= '0;
      owner_reg         <= '0;
      rr_ptr_reg        <= LAST_IDX;
      hold_cnt_reg      <= '0;
      hmaster_reg       <= '0;
      hmaster_data_reg  <= '0;
      hmaster_valid_reg <= 1'b0;
    end else if (hready) begin
      state_reg         <= state_next;
      grant_reg         <= grant_next;
      owner_reg         <= owner_next;
      rr_ptr_reg        <= rr_ptr_next;
      hold_cnt_reg      <= hold_cnt_next;
      hmaster_reg       <= (|grant_reg) ? owner_reg : '0;
      hmaster_valid_reg <= |grant_reg;
      hmaster_data_reg  <= hmaster_reg;
    end
  end

  assign hgrant        = grant_reg;
  assign hmaster       = hmaster_reg;
  assign hmaster_data  = hmaster_data_reg;
  assign hmaster_valid = hmaster_valid_reg;

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 3, meaning number of masters sharing this slave port.
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning the number of completed beats after which the owner may be pre-empted.
REQ-003 SHALL have parameter IDX_W, default $clog2(MASTER_NUM), meaning the master index width.
REQ-004 SHALL have port hclk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port hreset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port hreq, input, MASTER_NUM, per-master request to this slave, taken from each master's decoder.
REQ-007 SHALL have port htrans, input, MASTER_NUM x htrans_type, per-master transfer type.
REQ-008 SHALL have port hready, input, 1, slave ready; arbitration and ownership advance only when it is 1.
REQ-009 SHALL have port hgrant, output, MASTER_NUM, registered, one-hot or zero.
REQ-010 SHALL have port hmaster, output, IDX_W, address-phase owner index.
REQ-011 SHALL have port hmaster_data, output, IDX_W, data-phase owner index.
REQ-012 SHALL have port hmaster_valid, output, 1, meaning hmaster is a granted owner.

Function
REQ-013 SHALL implement FSM ARB_IDLE / ARB_OWN; state, hgrant and hold_cnt SHALL change only on edges with hready=1.
REQ-014 In ARB_IDLE with any hreq bit set, the block SHALL grant the round-robin winner and go to ARB_OWN.
- Search starts at rr_ptr+1, modulo MASTER_NUM.
- rr_ptr SHALL be loaded with the winner index.
REQ-015 In ARB_IDLE with hreq=0, the block SHALL hold hgrant=0.
REQ-016 In ARB_OWN, the owner SHALL keep the grant while htrans[owner] is SEQ or BUSY (burst lock), regardless of other requests.
REQ-017 In ARB_OWN, release SHALL occur when hreq[owner]=0 or htrans[owner]=IDLE.
- Release means re-arbitrating among the other requesters.
- If none are requesting, the block SHALL return to ARB_IDLE with hgrant=0.
REQ-018 Pre-emption SHALL occur when all of the following hold: hold_cnt≥MAX_HOLD, htrans[owner] is IDLE or NONSEQ, and another hreq bit is set.
- The grant SHALL then pass to the next round-robin requester, excluding the owner.
REQ-019 hold_cnt SHALL increment on each hready=1 edge while htrans[owner] is NONSEQ or SEQ, and saturate at MAX_HOLD.
REQ-020 hold_cnt SHALL clear to 0 on every grant change.
REQ-021 If the only requester is the owner, it SHALL keep the grant even at hold_cnt≥MAX_HOLD.
REQ-022 The grant latency SHALL be one edge: hgrant SHALL be asserted on the first hready=1 edge after hreq rises in ARB_IDLE.
REQ-023 If hready=0, hgrant, hmaster, hmaster_data and the state SHALL hold, even if hreq changes.
REQ-024 On each hready=1 edge, the ownership pipeline SHALL advance:
- hmaster SHALL load the index of the currently asserted hgrant bit;
- hmaster_valid SHALL load |hgrant;
- hmaster_data SHALL load the old hmaster.
REQ-025 Simultaneous requests from all masters in ARB_IDLE after reset SHALL grant master 0 first.

Reset
REQ-026 On hreset=1 at an edge, regardless of hready or mid-burst, the block SHALL set:
- hgrant=0, hmaster=0, hmaster_data=0, hmaster_valid=0;
- hold_cnt=0, rr_ptr=MASTER_NUM-1, state=ARB_IDLE.
REQ-027 The first grant after reset deassertion SHALL follow REQ-014.

Structure
REQ-028 htrans_type (IDLE, BUSY, NONSEQ, SEQ) and the arbiter state enum SHALL live in AHB_package.
REQ-029 The round-robin winner search SHALL be a combinational sub-module ahb_rr_picker.
- Inputs: request vector, start pointer, exclude-mask.
- Outputs: winner index, found flag.
REQ-030 The block SHALL contain no other sub-modules; the implementation SHALL be 120-400 lines.

Verification (MASTER_NUM=3, MAX_HOLD=4)
REQ-031 Reset, then hreq=3'b111, hready=1 -> hgrant=001 after one edge, hmaster=0 after the second edge, hmaster_data=0 after the third edge.
REQ-032 Owner 0 does a SEQ burst of 8 beats with hreq=3'b011 -> hgrant stays 001 throughout; it moves to 010 on the first edge where htrans[0] is IDLE or NONSEQ.
REQ-033 Master 1 issues continuous NONSEQ singles while master 2 requests -> the grant moves to 100 on the edge after the 4th completed beat; hold_cnt returns to 0.
REQ-034 hready=0 for 3 cycles while hreq changes -> hgrant, hmaster, hmaster_data and state are unchanged; they update on the first hready=1 edge.
REQ-035 hreset=1 mid-burst -> all outputs are 0 on the next edge, and hreq=3'b100 afterwards grants master 2 first.
REQ-036 Only the owner is requesting, at hold_cnt=4 -> hgrant is unchanged; the owner releases with htrans=IDLE -> hgrant=000 and state=ARB_IDLE.
